// File: rtl/game_judge.sv
// game_judge: latches the round code, runs the defuse countdown, checks confirm presses and
// holds the result face before requesting a new round. `GAME_JUDGE_HINT_EN adds a hint output.
module game_judge #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TIME_S    = 20,
    parameter int unsigned MAX_TRIES = 3,
    parameter int unsigned HOLD_S    = 3
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       startInput,
    input  logic [4:0] random,
    input  logic [4:0] SW,
    input  logic       BTN,
    output logic [4:0] secs_left,
    output logic [2:0] tries_left,
    output logic       fail,
    output logic       success,
    output logic       repeatRst
`ifdef GAME_JUDGE_HINT_EN
    ,
    output logic [1:0] hint
`endif
);

    localparam int unsigned HOLD_CYC   = HOLD_S * CLK_HZ;
    localparam int unsigned PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned HW         = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC - 1);
    localparam logic [4:0]    SECS_INIT  = 5'(TIME_S);
    localparam logic [2:0]    TRIES_INIT = 3'(MAX_TRIES);

    typedef enum logic [1:0] {StIdle, StArmed, StSuccess, StFail} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [4:0]    secs_q, secs_d;
    logic [4:0]    code_q, code_d;
    logic [2:0]    tries_q, tries_d;
    logic          rpt_q, rpt_d;
    logic          btn_s1_q, btn_s2_q, btn_s3_q;
    logic          press, wrap, hold_done;
`ifdef GAME_JUDGE_HINT_EN
    logic [1:0]    hint_q, hint_d;
`endif

    // One-cycle strobe on the rising edge of the synchronized button.
    assign press     = btn_s2_q & ~btn_s3_q;
    assign wrap      = (presc_q == PRESC_MAX);
    assign hold_done = (hold_q == HOLD_MAX);

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            hold_q   <= '0;
            secs_q   <= SECS_INIT;
            tries_q  <= TRIES_INIT;
            code_q   <= '0;
            rpt_q    <= 1'b0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
`ifdef GAME_JUDGE_HINT_EN
            hint_q   <= 2'b00;
`endif
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            hold_q   <= hold_d;
            secs_q   <= secs_d;
            tries_q  <= tries_d;
            code_q   <= code_d;
            rpt_q    <= rpt_d;
            btn_s1_q <= BTN;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
`ifdef GAME_JUDGE_HINT_EN
            hint_q   <= hint_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        hold_d  = hold_q;
        secs_d  = secs_q;
        tries_d = tries_q;
        code_d  = code_q;
        rpt_d   = 1'b0;
`ifdef GAME_JUDGE_HINT_EN
        hint_d  = hint_q;
`endif
        unique case (state_q)
            StIdle: begin
                hold_d = '0;
                if (startInput) begin
                    state_d = StArmed;
                    code_d  = random;
                end
            end
            StArmed: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (!startInput) begin
                    state_d = StIdle;
                end else if (press && (SW == code_q)) begin
                    state_d = StSuccess;
                    hold_d  = '0;
`ifdef GAME_JUDGE_HINT_EN
                    hint_d  = 2'b00;
`endif
                end else begin
                    // A wrong press and the countdown wrap can both land on one edge.
                    if (press && (tries_q != 3'd0)) begin
                        tries_d = tries_q - 3'd1;
                        if (tries_q == 3'd1) state_d = StFail;
`ifdef GAME_JUDGE_HINT_EN
                        hint_d  = (SW < code_q) ? 2'b01 : 2'b10;
`endif
                    end
                    if (wrap && (secs_q != 5'd0)) begin
                        secs_d = secs_q - 5'd1;
                        if (secs_q == 5'd1) state_d = StFail;
                    end
                    if (state_d == StFail) hold_d = '0;
                end
            end
            StSuccess, StFail: begin
                if (!startInput) begin
                    state_d = StIdle;
                end else if (hold_done) begin
                    state_d = StIdle;
                    rpt_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Entering or sitting in idle restores the round defaults.
        if (state_d == StIdle) begin
            secs_d  = SECS_INIT;
            tries_d = TRIES_INIT;
`ifdef GAME_JUDGE_HINT_EN
            hint_d  = 2'b00;
`endif
        end
    end

    assign secs_left  = secs_q;
    assign tries_left = tries_q;
    assign fail       = (state_q == StFail);
    assign success    = (state_q == StSuccess);
    assign repeatRst  = rpt_q;
`ifdef GAME_JUDGE_HINT_EN
    assign hint       = hint_q;
`endif

endmodule

// File: tb/tb_game_judge.sv
// Bench for game_judge: directed vector table, hand-written corner sequences and a randomized
// run, all checked every cycle against a behavioural model of the game rules.
module tb_game_judge;

    localparam int CLK_HZ    = 4;
    localparam int TIME_S    = 3;
    localparam int MAX_TRIES = 3;
    localparam int HOLD_S    = 1;
    localparam int MIdle = 0, MArmed = 1, MSucc = 2, MFail = 3;

    logic       clk = 1'b0;
    logic       rst_p, startInput, BTN;
    logic [4:0] random, SW;
    logic [4:0] secs_left;
    logic [2:0] tries_left;
    logic       fail, success, repeatRst;
`ifdef GAME_JUDGE_HINT_EN
    logic [1:0] dut_hint;
`endif

    game_judge #(
        .CLK_HZ   (CLK_HZ),
        .TIME_S   (TIME_S),
        .MAX_TRIES(MAX_TRIES),
        .HOLD_S   (HOLD_S)
    ) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .startInput(startInput),
        .random    (random),
        .SW        (SW),
        .BTN       (BTN),
        .secs_left (secs_left),
        .tries_left(tries_left),
        .fail      (fail),
        .success   (success),
        .repeatRst (repeatRst)
`ifdef GAME_JUDGE_HINT_EN
        ,
        .hint      (dut_hint)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic [4:0] rnd;
        logic [4:0] sw;
        logic       btn;
        int         n;
        logic [4:0] secs;
        logic [2:0] tries;
        logic       fl;
        logic       sc;
        logic       rp;
        logic [1:0] hn;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_en = 0;

    // Reference model state: game rules expressed with elapsed-cycle arithmetic.
    int         m_mode = MIdle, m_k = 0, m_hold = 0, m_secs = TIME_S, m_tries = MAX_TRIES;
    int         m_code = 0;
    bit         m_rpt = 0;
    logic [1:0] m_hint = 2'b00;
    bit         h0 = 0, h1 = 0, h2 = 0;  // BTN samples at the last three edges

    task automatic go_idle();
        m_mode  = MIdle;
        m_secs  = TIME_S;
        m_tries = MAX_TRIES;
        m_hint  = 2'b00;
    endtask

    task automatic model_step();
        bit pr;
        pr = h1 && !h2;
        h2 = h1;
        h1 = h0;
        h0 = BTN;
        m_rpt = 0;
        if (rst_p) begin
            go_idle();
            m_code = 0;
            h0 = 0; h1 = 0; h2 = 0;
        end else begin
            case (m_mode)
                MIdle: if (startInput) begin
                    m_mode = MArmed;
                    m_code = int'(random);
                    m_k    = 0;
                end
                MArmed: begin
                    m_k++;
                    if (!startInput) go_idle();
                    else if (pr && int'(SW) == m_code) begin
                        m_mode = MSucc;
                        m_hold = 0;
                        m_hint = 2'b00;
                    end else begin
                        if (pr) begin
                            m_tries--;
                            m_hint = (int'(SW) < m_code) ? 2'b01 : 2'b10;
                        end
                        if (m_k % CLK_HZ == 0) m_secs = TIME_S - m_k / CLK_HZ;
                        if (m_tries == 0 || m_secs == 0) begin
                            m_mode = MFail;
                            m_hold = 0;
                        end
                    end
                end
                default: begin
                    if (!startInput) go_idle();
                    else begin
                        m_hold++;
                        if (m_hold == HOLD_S * CLK_HZ) begin
                            go_idle();
                            m_rpt = 1;
                        end
                    end
                end
            endcase
        end
    endtask

    function automatic logic [12:0] dut_vec();
`ifdef GAME_JUDGE_HINT_EN
        return {secs_left, tries_left, fail, success, repeatRst, dut_hint};
`else
        return {secs_left, tries_left, fail, success, repeatRst, 2'b00};
`endif
    endfunction

    task automatic check_model();
        logic [12:0] act, exp;
        act = dut_vec();
        exp = {5'(m_secs), 3'(m_tries), m_mode == MFail, m_mode == MSucc, m_rpt, 2'b00};
`ifdef GAME_JUDGE_HINT_EN
        exp[1:0] = m_hint;
`endif
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model cyc=%0d actual=%h required=%h", cyc, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        if (chk_en) check_model();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [4:0] rn, input logic [4:0] sw,
                       input logic b, input int n, input logic [4:0] es, input logic [2:0] et,
                       input logic ef, input logic esc, input logic er, input logic [1:0] eh);
        vec_t v;
        v.rst = r; v.start = s; v.rnd = rn; v.sw = sw; v.btn = b; v.n = n;
        v.secs = es; v.tries = et; v.fl = ef; v.sc = esc; v.rp = er; v.hn = eh;
        tbl.push_back(v);
    endtask

    initial begin
        int first_succ, rpt_t, pulses;
        bit prev, wide, succ_at_rpt;
        logic [12:0] act, exp;

        // rst start random     SW         btn n   secs tries fail succ rpt hint
        add(1, 0, 5'b00000, 5'b00000, 0, 2, 3, 3, 0, 0, 0, 2'b00);  // reset
        add(0, 1, 5'b10110, 5'b10110, 0, 1, 3, 3, 0, 0, 0, 2'b00);  // arm, correct code
        add(0, 1, 5'b10110, 5'b10110, 1, 2, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b10110, 5'b10110, 1, 1, 3, 3, 0, 1, 0, 2'b00);  // 3rd edge: success
        add(0, 1, 5'b10110, 5'b10110, 1, 2, 3, 3, 0, 1, 0, 2'b00);  // held BTN counts once
        add(0, 1, 5'b10110, 5'b10110, 0, 1, 3, 3, 0, 1, 0, 2'b00);
        add(0, 1, 5'b10110, 5'b10110, 0, 1, 3, 3, 0, 0, 1, 2'b00);  // repeatRst, success drops
        add(0, 0, 5'b10110, 5'b10110, 0, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b10110, 5'b00001, 0, 1, 3, 3, 0, 0, 0, 2'b00);  // wrong entries
        add(0, 1, 5'b10110, 5'b00001, 1, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b10110, 5'b00001, 0, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b10110, 5'b00001, 1, 1, 3, 2, 0, 0, 0, 2'b01);
        add(0, 1, 5'b10110, 5'b00001, 0, 1, 2, 2, 0, 0, 0, 2'b01);
        add(0, 1, 5'b10110, 5'b00001, 1, 1, 2, 1, 0, 0, 0, 2'b01);
        add(0, 1, 5'b10110, 5'b00001, 0, 1, 2, 1, 0, 0, 0, 2'b01);
        add(0, 1, 5'b10110, 5'b00001, 1, 1, 2, 0, 1, 0, 0, 2'b01);  // out of tries
        add(0, 1, 5'b10110, 5'b00001, 0, 3, 2, 0, 1, 0, 0, 2'b01);
        add(0, 1, 5'b10110, 5'b00001, 0, 1, 3, 3, 0, 0, 1, 2'b00);
        add(0, 0, 5'b10110, 5'b00001, 0, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b00011, 5'b00000, 0, 4, 3, 3, 0, 0, 0, 2'b00);  // timeout
        add(0, 1, 5'b00011, 5'b00000, 0, 1, 2, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b00011, 5'b00000, 0, 4, 1, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b00011, 5'b00000, 0, 3, 1, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b00011, 5'b00000, 0, 1, 0, 3, 1, 0, 0, 2'b00);
        add(0, 1, 5'b00011, 5'b00000, 0, 3, 0, 3, 1, 0, 0, 2'b00);
        add(0, 1, 5'b00011, 5'b00000, 0, 1, 3, 3, 0, 0, 1, 2'b00);
        add(0, 0, 5'b00011, 5'b00000, 0, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b01010, 5'b01010, 0, 1, 3, 3, 0, 0, 0, 2'b00);  // correct press on final wrap
        add(0, 1, 5'b01010, 5'b01010, 0, 9, 1, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b01010, 5'b01010, 1, 2, 1, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b01010, 5'b01010, 1, 1, 1, 3, 0, 1, 0, 2'b00);
        add(0, 0, 5'b01010, 5'b01010, 0, 1, 3, 3, 0, 0, 0, 2'b00);  // abort during hold
        add(0, 1, 5'b01010, 5'b11111, 0, 1, 3, 3, 0, 0, 0, 2'b00);  // wrong press on final wrap
        add(0, 1, 5'b01010, 5'b11111, 0, 9, 1, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b01010, 5'b11111, 1, 2, 1, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b01010, 5'b11111, 1, 1, 0, 2, 1, 0, 0, 2'b10);
        add(0, 0, 5'b01010, 5'b11111, 0, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 1, 5'b01010, 5'b11111, 0, 5, 2, 3, 0, 0, 0, 2'b00);  // abort at secs_left=2
        add(0, 0, 5'b01010, 5'b11111, 0, 1, 3, 3, 0, 0, 0, 2'b00);
        add(0, 0, 5'b01010, 5'b11111, 0, 6, 3, 3, 0, 0, 0, 2'b00);

        foreach (tbl[i]) begin
            rst_p      = tbl[i].rst;
            startInput = tbl[i].start;
            random     = tbl[i].rnd;
            SW         = tbl[i].sw;
            BTN        = tbl[i].btn;
            repeat (tbl[i].n) cycle();
            chk_en = 1;
            act = dut_vec();
            exp = {tbl[i].secs, tbl[i].tries, tbl[i].fl, tbl[i].sc, tbl[i].rp, 2'b00};
`ifdef GAME_JUDGE_HINT_EN
            exp[1:0] = tbl[i].hn;
`endif
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL vec row=%0d actual=%h required=%h", i, act, exp);
            end
        end

        // repeatRst timing and width after a correct entry
        rst_p = 0; startInput = 0; BTN = 0;
        repeat (2) cycle();
        random = 5'b01101; SW = 5'b01101; startInput = 1;
        cycle();
        BTN = 1; first_succ = -1; rpt_t = -1; pulses = 0; prev = 0; wide = 0; succ_at_rpt = 1;
        for (int t = 1; t <= 30; t++) begin
            cycle();
            if (t == 3) BTN = 0;
            if (success && first_succ < 0) first_succ = t;
            if (repeatRst) begin
                if (prev) wide = 1;
                pulses++;
                if (rpt_t < 0) begin
                    rpt_t = t;
                    succ_at_rpt = success;
                end
                startInput = 0;
            end
            prev = repeatRst;
        end
        chk("succ_latency", first_succ, 3);
        chk("rpt_count", pulses, 1);
        chk("rpt_width", int'(wide), 0);
        chk("rpt_delay", rpt_t - first_succ, 4);
        chk("succ_at_rpt", int'(succ_at_rpt), 0);

        // reset during the success hold aborts without a pulse
        random = 5'b00100; SW = 5'b00100; startInput = 1; BTN = 0;
        cycle();
        BTN = 1;
        repeat (3) cycle();
        chk("hold_success", int'(success), 1);
        rst_p = 1;
        cycle();
        chk("rst_hold_success", int'(success), 0);
        rst_p = 0; startInput = 0; BTN = 0; pulses = 0;
        repeat (12) begin
            cycle();
            if (repeatRst) pulses++;
        end
        chk("rst_no_rpt", pulses, 0);

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            rst_p      = ($urandom_range(0, 249) == 0);
            startInput = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 15) == 0) random = 5'($urandom);
            if ($urandom_range(0, 2) == 0) SW = random;
            else if ($urandom_range(0, 3) == 0) SW = 5'($urandom);
            if ($urandom_range(0, 3) == 0) BTN = ~BTN;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_judge.md
Name: game_judge

Overview:
- Password-input verification and game-outcome block of the bomb game; consumer end of the game controller's start/code interface.
- Latches the random code when input is enabled and runs the 20 s defuse countdown.
- Checks player switch entries on each confirm press and drives the fail/success face enables.
- Returns a one-cycle repeatRst pulse to the controller after the result display time, so a new round starts automatically.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per countdown second.
- TIME_S, 20, countdown length in seconds (≤31).
- MAX_TRIES, 3, wrong entries allowed before fail (1..7).
- HOLD_S, 3, seconds the result face is held before repeatRst.

Ports:
- clk  input  1  system clock
- rst_p  input  1  reset; synchronous, active-high
- startInput  input  1  level from controller; 1 enables input/verification
- random  input  5  code from controller; sampled at arm
- SW  input  5  player entry switches, already stable/synchronous
- BTN  input  1  raw confirm button, asynchronous
- secs_left  output  5  remaining countdown seconds, for the timer display
- tries_left  output  3  remaining attempts
- fail  output  1  crying-face enable
- success  output  1  smiling-face enable
- repeatRst  output  1  one-cycle pulse to controller requesting a new round

Behaviour:
- One clock. Reset is synchronous and active-high on rst_p (polarity and synchronicity fixed); all state updates on posedge clk.
- Reset values:
  - state=IDLE
  - secs_left=TIME_S, tries_left=MAX_TRIES
  - fail=0, success=0, repeatRst=0
  - prescaler=0, code_q=0, button sync flops=0
- Reset mid-round aborts immediately: no repeatRst.
- Button path:
  - BTN passes through a 2-flop synchronizer plus a third history flop.
  - press = s2 & ~s3: a single cycle per press, so holding BTN counts once.
  - Result registers on the edge after press. fail/success are high 3 clock edges after BTN is first sampled high.
- State IDLE:
  - Outputs fail=0, success=0.
  - Holds secs_left=TIME_S and tries_left=MAX_TRIES.
  - Moves to ARMED on any cycle with startInput=1. On that edge: code_q<=random, prescaler<=0.
- State ARMED:
  - Prescaler counts 0..CLK_HZ-1 and wraps; each wrap decrements secs_left.
  - Timeout: wrap while secs_left==1 sets secs_left<=0 and moves to FAIL.
  - On press with SW==code_q: move to SUCCESS; secs_left freezes.
  - On press with SW!=code_q: tries_left decrements. If tries_left was 1, it becomes 0 and the block moves to FAIL.
  - Simultaneous press and timeout wrap: the press is evaluated first. A correct entry goes to SUCCESS; a wrong entry goes to FAIL.
  - startInput=0 returns to IDLE (abort); no fail/success/repeatRst.
  - Presses in any other state are ignored.
- States SUCCESS / FAIL:
  - The matching output is held at 1 for HOLD_S×CLK_HZ cycles; the hold counter restarts at entry.
  - At hold expiry: repeatRst=1 for exactly one cycle, then IDLE (fail/success drop on the same edge repeatRst rises).
  - startInput=0 during hold: go to IDLE at once, no pulse.
- repeatRst is never high for more than one consecutive cycle, and never high outside hold expiry.
- Counter widths are sized with $clog2. secs_left never underflows below 0. tries_left never underflows.

Optional Feature:
- Macro: GAME_JUDGE_HINT_EN.
- When defined:
  - Adds output hint[1:0], registered on each wrong press: 2'b01 when SW<code_q, 2'b10 when SW>code_q.
  - hint is cleared to 0 on reset, in IDLE, and on a correct press.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Overrides for all scenarios: CLK_HZ=4, TIME_S=3, MAX_TRIES=3, HOLD_S=1.
- Reset scenario: hold rst_p=1 for 2 clocks -> secs_left=3, tries_left=3, fail=success=repeatRst=0, state IDLE.
- Correct entry: startInput=1, random=5'b10110, SW=5'b10110, BTN high 5 cycles -> success=1 on 3rd edge, only one press counted. repeatRst high exactly one cycle 4 cycles later, success=0 on that edge.
- Wrong entries: SW=5'b00001, three separate presses -> tries_left 2, 1, 0. fail=1 after the 3rd press. With HINT_EN defined, hint=2'b01 after each press.
- Timeout: arm with no presses -> secs_left 3→2→1→0 at cycles 4, 8, 12 after arm; fail=1 at cycle 12; repeatRst 4 cycles later.
- Simultaneous correct press and final wrap -> success=1, fail stays 0. Same stimulus with a wrong SW -> fail=1, tries_left decremented.
- Abort and reset: startInput=0 in ARMED at secs_left=2 -> IDLE, no repeatRst. rst_p=1 during SUCCESS hold -> success=0 next edge, no repeatRst pulse ever.
